cart_sram_ctrl: RTL and testbench

Sequencer for the external byte-wide cartridge SRAM, shared between two requesters: ROM download writes from the data_io path and cartridge reads from cv_console. It replaces the combinational address mux on the SRAM pins with a timed state machine. The machine drives proper write setup, pulse and hold phases and registers read data. Download writes cannot be back-pressured, so each one is absorbed into a one-entry holding register. Writes have priority over reads.

---
 rtl/cart_sram_pkg.sv | 15 +
 rtl/cart_sram_ctrl.sv | 151 +++++++++++++++
 tb/tb_cart_sram_ctrl.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cart_sram_pkg.sv
// Shared definitions for the cartridge SRAM sequencer.
// Holds the FSM state encoding and the default access/pulse width.
package cart_sram_pkg;

  localparam int WAIT_CYCLES_DEF = 2;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD       = 3'd1,
    ST_WR_SETUP = 3'd2,
    ST_WR_PULSE = 3'd3,
    ST_WR_HOLD  = 3'd4
  } state_t;

endpackage

// File: rtl/cart_sram_ctrl.sv
// Cartridge SRAM sequencer: download writes (one-entry holding reg, priority) and cart reads.
// Read data valid WAIT_CYCLES+1 after an idle strobe; downloads are never stalled, excess writes set overrun.
module cart_sram_ctrl
  import cart_sram_pkg::*;
#(
  parameter int ADDR_W      = 21,
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              dl_active,
  input  logic              dl_wr,
  input  logic [ADDR_W-1:0] dl_addr,
  input  logic [7:0]        dl_data,
  input  logic              cart_rd,
  input  logic [19:0]       cart_a,
  output logic [7:0]        cart_d,
  output logic              cart_valid,
  output logic              overrun,
  output logic [ADDR_W-1:0] sram_a,
  output logic [7:0]        sram_dq_o,
  output logic              sram_dq_oe,
  input  logic [7:0]        sram_dq_i,
  output logic              sram_we_n,
  output logic              sram_oe_n
);

  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              wr_pend;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              rd_pend;
  logic [ADDR_W-1:0] rd_addr;
  logic              dl_active_q;

  logic [ADDR_W-1:0] cart_a_ext;
  logic              wr_go;
  logic              rd_go;
  logic              hold_load;
  logic              wr_drop;
  logic              cnt_last;

  assign cart_a_ext = ADDR_W'(cart_a);
  assign cnt_last   = (cnt == CNT_LAST);
  // Strobes are dispatched at the edge they are sampled; a write always beats a read.
  assign wr_go      = (state == ST_IDLE) && (wr_pend || dl_wr);
  assign rd_go      = (state == ST_IDLE) && !wr_go && !dl_active && (rd_pend || cart_rd);
  // A strobe is held when it cannot go straight out, or when the held write leaves this edge.
  assign hold_load  = dl_wr && (wr_pend ? wr_go : !wr_go);
  assign wr_drop    = dl_wr && wr_pend && !wr_go;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      wr_pend     <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= 8'h00;
      rd_pend     <= 1'b0;
      rd_addr     <= '0;
      overrun     <= 1'b0;
      dl_active_q <= 1'b0;
    end else begin
      dl_active_q <= dl_active;
      if (hold_load) begin
        wr_pend <= 1'b1;
        wr_addr <= dl_addr;
        wr_data <= dl_data;
      end else if (wr_go) begin
        wr_pend <= 1'b0;
      end
      if (dl_active) begin
        rd_pend <= 1'b0;
      end else if (cart_rd) begin
        rd_pend <= !rd_go;
        rd_addr <= cart_a_ext;
      end else if (rd_go) begin
        rd_pend <= 1'b0;
      end
      if (dl_active && !dl_active_q) overrun <= 1'b0;
      if (wr_drop)                   overrun <= 1'b1;
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      sram_a     <= '0;
      sram_dq_o  <= 8'h00;
      sram_dq_oe <= 1'b0;
      sram_we_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      cart_d     <= 8'hFF;
      cart_valid <= 1'b0;
    end else begin
      cart_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (wr_go) begin
            state      <= ST_WR_SETUP;
            sram_a     <= wr_pend ? wr_addr : dl_addr;
            sram_dq_o  <= wr_pend ? wr_data : dl_data;
            sram_dq_oe <= 1'b1;
          end else if (rd_go) begin
            state     <= ST_RD;
            sram_a    <= cart_rd ? cart_a_ext : rd_addr;
            sram_oe_n <= 1'b0;
            cnt       <= '0;
          end
        end
        ST_RD: begin
          if (cnt_last) begin
            state      <= ST_IDLE;
            sram_oe_n  <= 1'b1;
            cart_d     <= sram_dq_i;
            cart_valid <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_WR_SETUP: begin
          state     <= ST_WR_PULSE;
          sram_we_n <= 1'b0;
          cnt       <= '0;
        end
        ST_WR_PULSE: begin
          if (cnt_last) begin
            state     <= ST_WR_HOLD;
            sram_we_n <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_WR_HOLD: begin
          state      <= ST_IDLE;
          sram_dq_oe <= 1'b0;
        end
        default: begin
          state      <= ST_IDLE;
          sram_we_n  <= 1'b1;
          sram_oe_n  <= 1'b1;
          sram_dq_oe <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cart_sram_ctrl.sv
// Bench for cart_sram_ctrl: SRAM byte model, reference memory, and a read-data scoreboard.
module tb_cart_sram_ctrl;

  localparam int AW = 21;

  logic          clk_sys   = 1'b0;
  logic          reset     = 1'b1;
  logic          dl_active = 1'b0;
  logic          dl_wr     = 1'b0;
  logic [AW-1:0] dl_addr   = '0;
  logic [7:0]    dl_data   = 8'h00;
  logic          cart_rd   = 1'b0;
  logic [19:0]   cart_a    = 20'h0;
  logic [7:0]    cart_d;
  logic          cart_valid;
  logic          overrun;
  logic [AW-1:0] sram_a;
  logic [7:0]    sram_dq_o;
  logic          sram_dq_oe;
  logic [7:0]    sram_dq_i = 8'h00;
  logic          sram_we_n;
  logic          sram_oe_n;

  always #5 clk_sys = ~clk_sys;

  cart_sram_ctrl #(.ADDR_W(AW), .WAIT_CYCLES(2)) dut (
    .clk_sys(clk_sys), .reset(reset), .dl_active(dl_active),
    .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data),
    .cart_rd(cart_rd), .cart_a(cart_a), .cart_d(cart_d),
    .cart_valid(cart_valid), .overrun(overrun), .sram_a(sram_a),
    .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe), .sram_dq_i(sram_dq_i),
    .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n)
  );

  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  // Power-up SRAM contents; 0x00123 holds 8'h5A.
  function automatic logic [7:0] def_byte(input int a);
    return 8'(a) ^ 8'(a >> 8) ^ 8'h78;
  endfunction

  // Physical SRAM: byte captured on the rising edge of we_n.
  logic [7:0] mem [int];
  function automatic logic [7:0] mem_rd(input int a);
    return mem.exists(a) ? mem[a] : def_byte(a);
  endfunction
  always @(posedge sram_we_n) if (!reset && sram_dq_oe) mem[int'(sram_a)] = sram_dq_o;
  always @(negedge clk_sys) sram_dq_i = sram_oe_n ? 8'h00 : mem_rd(int'(sram_a));

  // Reference: memory contents as seen by every accepted download write.
  logic [7:0] ref_mem [int];
  function automatic logic [7:0] ref_rd(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : def_byte(a);
  endfunction

  typedef struct { logic [7:0] d; int cyc; } exp_t;
  exp_t exp_q[$];

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk_sys);
      if (!reset) begin
        chk("bus_contention", int'(!sram_oe_n && sram_dq_oe), 0);
        if (cart_valid) begin
          if (exp_q.size() == 0) chk("unexpected_valid", 1, 0);
          else begin
            e = exp_q.pop_front();
            chk("rd_data", cart_d, e.d);
            chk("rd_cycle", cyc, e.cyc);
          end
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic wr(input int a, input logic [7:0] d);
    dl_wr = 1'b1; dl_addr = AW'(a); dl_data = d;
    tick();
    dl_wr = 1'b0;
  endtask

  task automatic rd(input int a, input logic [7:0] d, input int lat);
    exp_q.push_back('{d: d, cyc: cyc + lat});
    cart_rd = 1'b1; cart_a = 20'(a);
    tick();
    cart_rd = 1'b0;
  endtask

  task automatic drain(input int max);
    for (int i = 0; i < max && exp_q.size() != 0; i++) tick();
    chk("drain_timeout", exp_q.size(), 0);
  endtask

  function automatic int pool(input int i);
    return 32'h100 + i * 32'h111;
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_we_n"}, sram_we_n, 1);
    chk({tag, "_oe_n"}, sram_oe_n, 1);
    chk({tag, "_dq_oe"}, sram_dq_oe, 0);
    chk({tag, "_sram_a"}, sram_a, 0);
    chk({tag, "_dq_o"}, sram_dq_o, 0);
    chk({tag, "_cart_d"}, cart_d, 8'hFF);
    chk({tag, "_cart_valid"}, cart_valid, 0);
    chk({tag, "_overrun"}, overrun, 0);
  endtask

  initial begin
    int a, b, op, k;
    logic [7:0] d;
    fork monitor(); join_none

    repeat (3) @(posedge clk_sys);
    #1;
    chk_reset_outputs("por");
    reset = 1'b0;
    tick(); tick();

    // Idle read: oe_n low two cycles at the strobe address, data three cycles later.
    rd(32'h123, 8'h5A, 3);
    @(negedge clk_sys);
    chk("rd_oe_n_c1", sram_oe_n, 0);
    chk("rd_addr_c1", sram_a, 32'h123);
    chk("rd_dq_oe_c1", sram_dq_oe, 0);
    tick(); @(negedge clk_sys);
    chk("rd_oe_n_c2", sram_oe_n, 0);
    tick(); @(negedge clk_sys);
    chk("rd_oe_n_c3", sram_oe_n, 1);
    repeat (3) tick();
    chk("rd_cart_d_held", cart_d, 8'h5A);

    // Write phases: setup, two-cycle pulse, hold, then bus released.
    ref_mem[32'h4000] = 8'hA5;
    wr(32'h4000, 8'hA5);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk_sys);
      chk($sformatf("wr_we_n_c%0d", c), sram_we_n, (c == 2 || c == 3) ? 0 : 1);
      chk($sformatf("wr_dq_oe_c%0d", c), sram_dq_oe, (c <= 4) ? 1 : 0);
      if (c <= 4) begin
        chk($sformatf("wr_addr_c%0d", c), sram_a, 32'h4000);
        chk($sformatf("wr_data_c%0d", c), sram_dq_o, 8'hA5);
      end
      tick();
    end
    chk("wr_model_byte", mem_rd(32'h4000), 8'hA5);
    rd(32'h4000, 8'hA5, 3);
    drain(20);

    // Simultaneous write and read: write first, read sees the new byte 8 cycles later.
    ref_mem[32'h777] = 8'h3C;
    exp_q.push_back('{d: 8'h3C, cyc: cyc + 8});
    dl_wr = 1'b1; dl_addr = AW'(32'h777); dl_data = 8'h3C;
    cart_rd = 1'b1; cart_a = 20'h00777;
    tick();
    dl_wr = 1'b0; cart_rd = 1'b0;
    drain(30);

    // Randomised mix of writes and reads with no overruns.
    for (int it = 0; it < 60; it++) begin
      op = $urandom_range(0, 4);
      a  = pool($urandom_range(0, 15));
      b  = pool($urandom_range(0, 15));
      d  = 8'($urandom);
      k  = $urandom_range(0, 1);
      case (op)
        0: begin
          ref_mem[a] = d;
          wr(a, d);
          repeat (4 + $urandom_range(0, 3)) tick();
        end
        1: begin
          rd(a, ref_rd(a), 3);
          drain(20);
          repeat ($urandom_range(0, 2)) tick();
        end
        2: begin
          rd(a, ref_rd(a), 3);
          if (k == 1) tick();
          ref_mem[a] = d;
          wr(a, d);
          drain(20);
          repeat (6) tick();
        end
        3: begin
          rd(a, ref_rd(a), 3);
          if (k == 1) tick();
          rd(b, ref_rd(b), 5 - k);
          drain(20);
        end
        default: begin
          ref_mem[a] = d;
          exp_q.push_back('{d: d, cyc: cyc + 8});
          dl_wr = 1'b1; dl_addr = AW'(a); dl_data = d;
          cart_rd = 1'b1; cart_a = 20'(a);
          tick();
          dl_wr = 1'b0; cart_rd = 1'b0;
          drain(30);
        end
      endcase
    end
    chk("no_overrun_random", overrun, 0);

    // Third write lands while one is in flight and one is held: dropped.
    ref_mem[32'h2000] = 8'h11;
    ref_mem[32'h2001] = 8'h22;
    wr(32'h2000, 8'h11);
    wr(32'h2001, 8'h22);
    tick();
    wr(32'h2002, 8'h33);
    @(negedge clk_sys);
    chk("overrun_set", overrun, 1);
    repeat (12) tick();
    chk("overrun_sticky", overrun, 1);
    rd(32'h2002, ref_rd(32'h2002), 3);
    drain(20);
    rd(32'h2001, 8'h22, 3);
    drain(20);

    // Download active: rise clears overrun, reads are ignored.
    dl_active = 1'b1;
    tick();
    @(negedge clk_sys);
    chk("overrun_cleared", overrun, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      cart_rd = 1'b1; cart_a = 20'(pool(i));
      tick();
      cart_rd = 1'b0;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk_sys);
        chk("dl_no_read", sram_oe_n, 1);
        tick();
      end
    end
    ref_mem[32'h2003] = 8'h44;
    wr(32'h2003, 8'h44);
    repeat (6) tick();
    dl_active = 1'b0;
    tick();
    rd(32'h2003, 8'h44, 3);
    drain(20);

    // Reset in the middle of the write pulse.
    wr(32'h3000, 8'h99);
    tick();
    chk("pulse_before_reset", sram_we_n, 0);
    #2 reset = 1'b1;
    #1;
    chk_reset_outputs("rst_wr");
    @(negedge clk_sys) reset = 1'b0;
    tick();

    // Reset in the middle of a read: no cart_valid may follow.
    cart_rd = 1'b1; cart_a = 20'h00123;
    tick();
    cart_rd = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("rst_rd_oe_n", sram_oe_n, 1);
    chk("rst_rd_cart_d", cart_d, 8'hFF);
    @(negedge clk_sys) reset = 1'b0;
    repeat (6) tick();
    chk("rst_rd_no_pending", exp_q.size(), 0);

    rd(32'h4000, 8'hA5, 3);
    drain(20);
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
